// File: rtl/gcd_lcm_pkg.sv
// gcd_lcm_pkg: shared types and constants for the GCD/LCM coprocessor
package gcd_lcm_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic OP_GCD = 1'b0;
  localparam logic OP_LCM = 1'b1;
  typedef enum logic [2:0] {IDLE, GCD, DIV, MUL, DONE} state_t;
  function automatic int k_width(input int w);
    return $clog2(w) + 1;
  endfunction
endpackage

// File: rtl/lcm_muldiv.sv
// lcm_muldiv: sequential q = dividend / divisor, then p = q * mcand, WIDTH cycles each
module lcm_muldiv
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_dividend,
  input  logic [WIDTH-1:0]   i_divisor,
  input  logic [WIDTH-1:0]   i_mcand,
  output logic               o_div_done,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_prod
);
  localparam int CW = $clog2(WIDTH);
  logic             r_run, r_mul;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_d, r_hi, r_lo;
  logic             w_last, w_ge;
  logic [WIDTH:0]   w_sh, w_rem, w_sum;
  assign w_last     = r_cnt == CW'(WIDTH - 1);
  assign o_div_done = r_run && !r_mul && w_last;
  assign o_done     = r_run && r_mul && w_last;
  // r_hi/r_lo are remainder/quotient while dividing, then product high/low while multiplying
  assign w_sh  = {r_hi, r_lo[WIDTH-1]};
  assign w_ge  = w_sh >= {1'b0, r_d};
  assign w_rem = w_ge ? w_sh - {1'b0, r_d} : w_sh;
  assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, i_mcand} : '0);
  assign o_prod = {w_sum, r_lo[WIDTH-1:1]};
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_run <= 1'b0;
      r_mul <= 1'b0;
      r_cnt <= '0;
      r_d   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (i_start) begin
      r_run <= 1'b1;
      r_mul <= 1'b0;
      r_cnt <= '0;
      r_d   <= i_divisor;
      r_hi  <= '0;
      r_lo  <= i_dividend;
    end else if (r_run) begin
      r_cnt <= w_last ? '0 : r_cnt + 1'b1;
      if (!r_mul) begin
        r_hi  <= w_last ? '0 : w_rem[WIDTH-1:0];
        r_lo  <= {r_lo[WIDTH-2:0], w_ge};
        r_mul <= w_last;
      end else begin
        {r_hi, r_lo} <= o_prod;
        r_run <= !w_last;
        r_mul <= !w_last;
      end
    end
  end
endmodule

// File: rtl/gcd_lcm_coproc.sv
// gcd_lcm_coproc: iterative GCD (binary Stein) / LCM responder with valid/ready handshakes
module gcd_lcm_coproc
  import gcd_lcm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_ovf,
  output logic             busy
);
  localparam int KW = k_width(WIDTH);
  state_t             r_state, w_next;
  logic               r_op, r_ovf;
  logic [WIDTH-1:0]   r_a, r_b, r_oa, r_ob, r_result;
  logic [KW-1:0]      r_k;
  logic               w_acc, w_zero, w_eq, w_start, w_div_done, w_mul_done;
  logic [WIDTH-1:0]   w_g;
  logic [2*WIDTH-1:0] w_prod;
  assign w_acc   = req_valid && req_ready;
  assign w_zero  = (req_a == '0) || (req_b == '0);
  assign w_eq    = r_a[0] && r_b[0] && (r_a == r_b);
  assign w_g     = r_a << r_k;
  assign w_start = (r_state == GCD) && w_eq && (r_op == OP_LCM);
  assign resp_result = r_result;
  assign resp_ovf    = r_ovf;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_acc) w_next = w_zero ? DONE : GCD;
      GCD:  if (w_eq) w_next = (r_op == OP_LCM) ? DIV : DONE;
      DIV:  if (w_div_done) w_next = MUL;
      MUL:  if (w_mul_done) w_next = DONE;
      DONE: if (resp_valid && resp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    req_ready  = r_state == IDLE;
    resp_valid = r_state == DONE;
    busy       = r_state != IDLE;
  end
  // a|b is already the GCD when an operand is zero; it is replaced on every other path
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_op     <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_oa     <= '0;
      r_ob     <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_ovf    <= 1'b0;
    end else if (r_state == IDLE && w_acc) begin
      r_op     <= req_op;
      r_a      <= req_a;
      r_b      <= req_b;
      r_oa     <= req_a;
      r_ob     <= req_b;
      r_k      <= '0;
      r_result <= (req_op == OP_LCM) ? '0 : (req_a | req_b);
      r_ovf    <= 1'b0;
    end else if (r_state == GCD) begin
      if (!r_a[0] && !r_b[0]) begin
        r_a <= r_a >> 1;
        r_b <= r_b >> 1;
        r_k <= r_k + 1'b1;
      end else if (!r_a[0]) r_a <= r_a >> 1;
      else if (!r_b[0]) r_b <= r_b >> 1;
      else if (r_a == r_b) r_result <= w_g;
      else if (r_a > r_b) r_a <= r_a - r_b;
      else r_b <= r_b - r_a;
    end else if (r_state == MUL && w_mul_done) begin
      r_result <= w_prod[WIDTH-1:0];
      r_ovf    <= |w_prod[2*WIDTH-1:WIDTH];
    end
  end
  lcm_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .reset      (reset),
    .i_start    (w_start),
    .i_dividend (r_oa),
    .i_divisor  (w_g),
    .i_mcand    (r_ob),
    .o_div_done (w_div_done),
    .o_done     (w_mul_done),
    .o_prod     (w_prod)
  );
endmodule

// File: tb/tb_gcd_lcm_coproc.sv
// tb_gcd_lcm_coproc: randomized and directed checks of gcd_lcm_coproc against an arithmetic model
module tb_gcd_lcm_coproc;
  localparam int W = 32;
  logic         clk = 1'b0, reset = 1'b0, req_valid = 1'b0, req_op = 1'b0, resp_ready = 1'b0;
  logic [W-1:0] req_a = '0, req_b = '0;
  logic         req_ready, resp_valid, resp_ovf, busy;
  logic [W-1:0] resp_result;
  int n_checks = 0, n_errors = 0;
  always #5 clk = ~clk;
  gcd_lcm_coproc #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_a       (req_a),
    .req_b       (req_b),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_ovf    (resp_ovf),
    .busy        (busy)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  function automatic longint unsigned ref_gcd(input longint unsigned a, input longint unsigned b);
    longint unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  // cycles spent in the Stein phase: one rule applied per cycle, the a==b rule included
  function automatic int ref_steps(input logic [W-1:0] a, input logic [W-1:0] b);
    int n = 0;
    if (a == 0 || b == 0) return 0;
    while (n < 1000) begin
      n++;
      if (!a[0] && !b[0]) begin a = a >> 1; b = b >> 1; end
      else if (!a[0]) a = a >> 1;
      else if (!b[0]) b = b >> 1;
      else if (a == b) return n;
      else if (a > b) a = a - b;
      else b = b - a;
    end
    return n;
  endfunction
  task automatic run_cmd(input logic op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    longint unsigned g, l, exp_res;
    logic exp_ovf;
    int lat, steps;
    logic zero;
    zero = (a == 0) || (b == 0);
    g = ref_gcd(longint'(a), longint'(b));
    l = zero ? 0 : (longint'(a) / g) * longint'(b);
    exp_res = op ? (l & 64'hFFFF_FFFF) : g;
    exp_ovf = op ? ((l >> 32) != 0) : 1'b0;
    steps = ref_steps(a, b) + ((op && !zero) ? 2 * W : 0);
    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!resp_valid && lat < 1000) begin
      if (lat == 1) check("req_ready_busy", req_ready, 0);
      req_valid = lat[0]; req_op = ~op; req_a = ~a; req_b = a ^ b;
      @(posedge clk); #1;
      lat++;
    end
    req_valid = 1'b0;
    check("resp_valid", resp_valid, 1);
    if (zero) check("zero_latency", lat <= 1, 1);
    else begin
      check("latency", lat, steps);
      check("gcd_phase_bound", (lat - (op ? 2 * W : 0)) <= 4 * W + 1, 1);
    end
    check("result", resp_result, exp_res);
    check("ovf", resp_ovf, exp_ovf);
    check("busy_done", busy, 1);
    check("req_ready_done", req_ready, 0);
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1; req_a = a + 1;
      @(posedge clk); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_result", resp_result, exp_res);
      check("hold_ovf", resp_ovf, exp_ovf);
    end
    req_valid = 1'b0;
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("valid_after_xfer", resp_valid, 0);
    check("ready_after_xfer", req_ready, 1);
    check("busy_after_xfer", busy, 0);
  endtask
  initial begin
    logic op;
    logic [W-1:0] a, b, f;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_result", resp_result, 0);
    check("rst_ovf", resp_ovf, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;
    run_cmd(1'b0, 32'd48, 32'd18, 0);
    run_cmd(1'b1, 32'd4, 32'd6, 0);
    run_cmd(1'b0, 32'd0, 32'd7, 0);
    run_cmd(1'b0, 32'd0, 32'd0, 0);
    run_cmd(1'b1, 32'd0, 32'd7, 0);
    run_cmd(1'b1, 32'd65536, 32'd65537, 5);
    run_cmd(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    run_cmd(1'b1, 32'h8000_0000, 32'h8000_0000, 0);
    for (int n = 0; n < 24; n++) begin
      op = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: begin a = $urandom_range(0, 40); b = $urandom_range(0, 40); end
        1: begin a = $urandom; b = $urandom; end
        default: begin
          f = $urandom_range(1, 4096);
          a = f * $urandom_range(1, 60000);
          b = f * $urandom_range(1, 60000);
        end
      endcase
      run_cmd(op, a, b, $urandom_range(0, 3));
    end
    @(negedge clk);
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd1; req_b = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (10) @(posedge clk);
    #3;
    check("busy_before_reset", busy, 1);
    reset = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_resp_valid", resp_valid, 0);
    check("midrst_result", resp_result, 0);
    check("midrst_ovf", resp_ovf, 0);
    check("midrst_busy", busy, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    run_cmd(1'b0, 32'd9, 32'd6, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
